// File: rtl/angle_stepper.sv
// Rotation-angle generator: steps a 0..MAX_DEG angle in STEP_DEG increments every
// (speed_in+1) frame ticks and hands each new angle downstream on a valid/ready handshake.
module angle_stepper #(
    parameter int STEP_DEG = 10,
    parameter int MAX_DEG  = 350,
    parameter int SPEED_W  = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               tick_in,
    input  logic               run_in,
    input  logic               dir_in,
    input  logic [SPEED_W-1:0] speed_in,
    input  logic               zero_in,
    input  logic               ready_in,
    output logic [8:0]         angle_out,
    output logic [1:0]         quadrant_out,
    output logic               angle_valid_out,
    output logic               wrap_out,
    output logic               overrun_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        PRESENT   = 2'd2
    } state_t;

    localparam logic [8:0] STEP_V = 9'(STEP_DEG);
    localparam logic [8:0] MAX_V  = 9'(MAX_DEG);

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [8:0]         angle_q, angle_d;
    logic [1:0]         quadrant_q, quadrant_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               overrun_q, overrun_d;

    // Quadrant boundaries are inclusive at the top: 90 is still quadrant 0.
    function automatic logic [1:0] quadrant_of(input logic [8:0] ang);
        logic [1:0] q;
        if (ang <= 9'd90) begin
            q = 2'd0;
        end else if (ang <= 9'd180) begin
            q = 2'd1;
        end else if (ang <= 9'd270) begin
            q = 2'd2;
        end else begin
            q = 2'd3;
        end
        return q;
    endfunction

    // Next-state, next-angle and handshake logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        angle_d    = angle_q;
        quadrant_d = quadrant_q;
        valid_d    = valid_q;
        wrap_d     = 1'b0;
        overrun_d  = overrun_q;

        if (zero_in) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            angle_d    = 9'd0;
            quadrant_d = 2'd0;
            valid_d    = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_in) begin
                        state_d = WAIT_TICK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_TICK: begin
                    if (!run_in) begin
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                    end else if (tick_in && (tick_cnt_q >= speed_in)) begin
                        tick_cnt_d = '0;
                        valid_d    = 1'b1;
                        state_d    = PRESENT;
                        if (!dir_in) begin
                            if (angle_q == MAX_V) begin
                                angle_d = 9'd0;
                                wrap_d  = 1'b1;
                            end else begin
                                angle_d = angle_q + STEP_V;
                            end
                        end else begin
                            if (angle_q == 9'd0) begin
                                angle_d = MAX_V;
                                wrap_d  = 1'b1;
                            end else begin
                                angle_d = angle_q - STEP_V;
                            end
                        end
                        quadrant_d = quadrant_of(angle_d);
                    end else if (tick_in) begin
                        tick_cnt_d = tick_cnt_q + SPEED_W'(1);
                    end else begin
                        tick_cnt_d = tick_cnt_q;
                    end
                end
                PRESENT: begin
                    // A tick while the angle is unaccepted is dropped, not counted.
                    if (tick_in) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                    if (ready_in) begin
                        valid_d = 1'b0;
                        if (run_in) begin
                            state_d = WAIT_TICK;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    valid_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            angle_q    <= 9'd0;
            quadrant_q <= 2'd0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            angle_q    <= angle_d;
            quadrant_q <= quadrant_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            overrun_q  <= overrun_d;
        end
    end

    assign angle_out       = angle_q;
    assign quadrant_out    = quadrant_q;
    assign angle_valid_out = valid_q;
    assign wrap_out        = wrap_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_angle_stepper.sv
// Directed bench for angle_stepper: per-cycle comparison against a degree-level
// behavioural model plus literal expectations at key points of each scenario.
module tb_angle_stepper;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       tick_in = 1'b0;
    logic       run_in = 1'b0;
    logic       dir_in = 1'b0;
    logic [3:0] speed_in = 4'd0;
    logic       zero_in = 1'b0;
    logic       ready_in = 1'b1;
    logic [8:0] angle_out;
    logic [1:0] quadrant_out;
    logic       angle_valid_out;
    logic       wrap_out;
    logic       overrun_out;

    int checks = 0;
    int errors = 0;

    angle_stepper dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tick_in         (tick_in),
        .run_in          (run_in),
        .dir_in          (dir_in),
        .speed_in        (speed_in),
        .zero_in         (zero_in),
        .ready_in        (ready_in),
        .angle_out       (angle_out),
        .quadrant_out    (quadrant_out),
        .angle_valid_out (angle_valid_out),
        .wrap_out        (wrap_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: angle in degrees, "armed" = stepping session active, "pending" = angle awaiting accept.
    int  m_angle = 0;
    int  m_cnt = 0;
    bit  m_armed = 0;
    bit  m_pending = 0;
    bit  m_wrap = 0;
    bit  m_ovr = 0;
    int  valid_rises = 0;
    int  wrap_pulses = 0;
    bit  prev_valid = 0;

    function automatic int quad_of(input int a);
        return (a == 0) ? 0 : (a - 1) / 90;
    endfunction

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_angle = 0; m_cnt = 0; m_armed = 0; m_pending = 0; m_wrap = 0; m_ovr = 0;
        end else if (zero_in) begin
            m_angle = 0; m_cnt = 0; m_armed = 0; m_pending = 0; m_wrap = 0; m_ovr = 0;
        end else begin
            m_wrap = 0;
            if (m_pending) begin
                if (tick_in) m_ovr = 1;
                if (ready_in) begin
                    m_pending = 0;
                    m_armed = run_in;
                end
            end else if (!m_armed) begin
                if (run_in) m_armed = 1;
            end else if (!run_in) begin
                m_armed = 0;
                m_cnt = 0;
            end else if (tick_in) begin
                if (m_cnt >= int'(speed_in)) begin
                    m_cnt = 0;
                    m_pending = 1;
                    if (dir_in) begin
                        m_wrap = (m_angle == 0);
                        m_angle = (m_angle + 350) % 360;
                    end else begin
                        m_wrap = (m_angle == 350);
                        m_angle = (m_angle + 10) % 360;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
        #2;
        chk("angle", int'(angle_out), m_angle);
        chk("quadrant", int'(quadrant_out), quad_of(m_angle));
        chk("valid", int'(angle_valid_out), int'(m_pending));
        chk("wrap", int'(wrap_out), int'(m_wrap));
        chk("overrun", int'(overrun_out), int'(m_ovr));
        if (angle_valid_out && !prev_valid) valid_rises++;
        if (wrap_out) wrap_pulses++;
        prev_valid = angle_valid_out;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic tick_once();
        tick_in = 1'b1;
        @(negedge clk_in);
        tick_in = 1'b0;
    endtask

    task automatic pulse_zero();
        zero_in = 1'b1;
        @(negedge clk_in);
        zero_in = 1'b0;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_once();
            cyc(1);
        end
    endtask

    initial begin
        cyc(3);
        chk("reset_angle", int'(angle_out), 0);
        chk("reset_valid", int'(angle_valid_out), 0);
        rst_in = 1'b0;
        run_in = 1'b1;
        cyc(1);

        // Full revolution at speed 0.
        valid_rises = 0;
        wrap_pulses = 0;
        step_n(35);
        chk("rev_350", int'(angle_out), 350);
        step_n(1);
        chk("rev_end_angle", int'(angle_out), 0);
        chk("rev_wraps", wrap_pulses, 1);
        chk("rev_valids", valid_rises, 36);
        chk("rev_overrun", int'(overrun_out), 0);

        // speed 3: one step per four ticks.
        speed_in = 4'd3;
        step_n(3);
        chk("spd_3ticks", int'(angle_out), 0);
        tick_once();
        chk("spd_4th_angle", int'(angle_out), 10);
        chk("spd_4th_valid", int'(angle_valid_out), 1);
        cyc(1);
        step_n(3);
        tick_once();
        chk("spd_8th_angle", int'(angle_out), 20);
        cyc(1);

        // Lowering speed below the running count steps on the next tick.
        step_n(2);
        speed_in = 4'd1;
        tick_once();
        chk("spd_lower", int'(angle_out), 30);
        cyc(1);

        // Decrement through zero.
        pulse_zero();
        cyc(1);
        speed_in = 4'd0;
        dir_in = 1'b1;
        tick_once();
        chk("dec_angle", int'(angle_out), 350);
        chk("dec_quad", int'(quadrant_out), 3);
        chk("dec_wrap", int'(wrap_out), 1);
        cyc(1);
        chk("dec_wrap_gone", int'(wrap_out), 0);
        tick_once();
        chk("dec_340", int'(angle_out), 340);
        chk("dec_340_wrap", int'(wrap_out), 0);
        cyc(1);

        // Backpressure and overrun.
        pulse_zero();
        cyc(1);
        dir_in = 1'b0;
        ready_in = 1'b0;
        tick_once();
        cyc(1);
        tick_once();
        cyc(1);
        tick_once();
        chk("bp_angle", int'(angle_out), 10);
        chk("bp_valid", int'(angle_valid_out), 1);
        chk("bp_overrun", int'(overrun_out), 1);
        ready_in = 1'b1;
        cyc(1);
        chk("bp_valid_drop", int'(angle_valid_out), 0);
        tick_once();
        chk("bp_next", int'(angle_out), 20);
        cyc(1);

        // Quadrant boundaries.
        step_n(7);
        chk("q_90", int'(quadrant_out), 0);
        step_n(1);
        chk("q_100", int'(quadrant_out), 1);
        step_n(8);
        chk("q_180", int'(quadrant_out), 1);
        step_n(1);
        chk("q_190", int'(quadrant_out), 2);

        // Zero during a pending presentation at 250.
        step_n(5);
        ready_in = 1'b0;
        tick_once();
        chk("z_pre_angle", int'(angle_out), 250);
        cyc(1);
        pulse_zero();
        chk("z_angle", int'(angle_out), 0);
        chk("z_valid", int'(angle_valid_out), 0);
        chk("z_overrun", int'(overrun_out), 0);
        ready_in = 1'b1;
        tick_once();
        chk("z_idle_tick", int'(angle_out), 0);

        // Reset mid-count, then reset mid-presentation.
        step_n(1);
        speed_in = 4'd3;
        step_n(2);
        rst_in = 1'b1;
        cyc(1);
        rst_in = 1'b0;
        chk("rst_angle", int'(angle_out), 0);
        chk("rst_valid", int'(angle_valid_out), 0);
        cyc(1);
        step_n(3);
        chk("rst_recount", int'(angle_out), 0);
        ready_in = 1'b0;
        tick_once();
        chk("rst_step", int'(angle_out), 10);
        rst_in = 1'b1;
        cyc(1);
        rst_in = 1'b0;
        chk("rst_present_valid", int'(angle_valid_out), 0);
        ready_in = 1'b1;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
